prog_loader: RTL and testbench

- Upstream program-load stage for the miniRV core.
- Accepts a framed byte stream on a valid/ready interface, assembles bytes into 32-bit little-endian words, and drives the core's load port (rom_wen / rom_wdata / rom_addr).
- Sequences the core's memory and register resets so the core runs only after a complete, checksum-verified image is written.

---
 rtl/miniRV_pkg.sv | 17 +
 rtl/byte_packer.sv | 34 +++
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miniRV_pkg.sv
// Shared definitions for the miniRV program-load path.
package miniRV_pkg;

    // Bytes in one little-endian word, also the length of the frame header.
    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit little-endian words. The completed word is
// presented combinationally alongside the 4th byte so the caller can register
// it on the same edge that accepts that byte.
module byte_packer
    import miniRV_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    // The three earlier bytes of the current word; the oldest sits in [7:0].
    logic [23:0] shift_reg;
    logic [1:0]  idx_reg;

    // Shift each new byte in from the top and count bytes modulo one word.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            shift_reg <= '0;
            idx_reg   <= '0;
        end else if (strobe) begin
            shift_reg <= {data, shift_reg[23:8]};
            idx_reg   <= idx_reg + 2'd1;
        end
    end

    assign word       = {data, shift_reg};
    assign word_valid = strobe && (idx_reg == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Program-load stage for the miniRV core: receives a framed, XOR-checksummed
// byte stream, writes the image through the core's load port and only then
// releases the core from reset.
module prog_loader
    import miniRV_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        rom_wen,
    output logic [31:0] rom_wdata,
    output logic [31:0] rom_addr,
    output logic        mem_reset,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

    loader_state_t state_reg;
    logic [31:0]   n_reg;
    logic [31:0]   word_idx_reg;
    logic [7:0]    csum_reg;

    logic          accept;
    logic          pack_clear;
    logic          pack_strobe;
    logic [31:0]   word;
    logic          word_valid;

    // in_ready is only ever high in HDR, DATA and CSUM, so accept implies one of those.
    assign accept      = in_valid && in_ready;
    assign pack_clear  = (state_reg == CLR);
    assign pack_strobe = accept && ((state_reg == HDR) || (state_reg == DATA));

    byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pack_clear),
        .strobe     (pack_strobe),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Loader FSM; every output is registered and set on the edge entering its state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            word_idx_reg <= '0;
            csum_reg     <= '0;
            in_ready     <= 1'b0;
            rom_wen      <= 1'b0;
            rom_wdata    <= '0;
            rom_addr     <= BASE_ADDR;
            mem_reset    <= 1'b0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rom_wen   <= 1'b0;
            mem_reset <= 1'b0;

            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_reg  <= CLR;
                        mem_reset  <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        in_ready   <= 1'b0;
                    end
                end

                CLR: begin
                    state_reg    <= HDR;
                    n_reg        <= '0;
                    word_idx_reg <= '0;
                    csum_reg     <= '0;
                    rom_addr     <= BASE_ADDR;
                    in_ready     <= 1'b1;
                end

                HDR: begin
                    if (accept) begin
                        csum_reg <= csum_reg ^ in_data;
                    end
                    if (word_valid) begin
                        n_reg <= word;
                        if (word > 32'(MAX_WORDS)) begin
                            state_reg <= ERROR;
                            err       <= 1'b1;
                            in_ready  <= 1'b0;
                        end else if (word == 32'd0) begin
                            state_reg <= CSUM;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        csum_reg <= csum_reg ^ in_data;
                    end
                    if (word_valid) begin
                        rom_wen      <= 1'b1;
                        rom_wdata    <= word;
                        rom_addr     <= BASE_ADDR + (word_idx_reg << 2);
                        word_idx_reg <= word_idx_reg + 32'd1;
                        if (word_idx_reg == n_reg - 32'd1) begin
                            state_reg <= CSUM;
                        end
                    end
                end

                CSUM: begin
                    if (accept) begin
                        // Compare before folding the candidate byte into the running XOR.
                        csum_reg <= csum_reg ^ in_data;
                        in_ready <= 1'b0;
                        if (in_data == csum_reg) begin
                            state_reg  <= DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state_reg  <= ERROR;
                            err        <= 1'b1;
                            core_reset <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stimulus pushes expected load-port writes
// into a queue, a negedge monitor pops and compares each rom_wen pulse.
module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        rom_wen;
    logic [31:0] rom_wdata;
    logic [31:0] rom_addr;
    logic        mem_reset;
    logic        core_reset;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (4096)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rom_wen    (rom_wen),
        .rom_wdata  (rom_wdata),
        .rom_addr   (rom_addr),
        .mem_reset  (mem_reset),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          mem_pulses = 0;
    int          starts = 0;
    logic [31:0] words[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_reset) mem_pulses++;
        if (mem_reset && rom_wen) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_reset_with_rom_wen: got both high expected exclusive");
        end
        if (rom_wen) begin
            $display("write addr=%h data=%h", rom_addr, rom_wdata);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", rom_addr, rom_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", rom_addr, e.addr);
                check("wr_data", rom_wdata, e.data);
            end
        end
    end

    function automatic logic [7:0] frame_csum(input logic [31:0] hdr, input int nw);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        for (int k = 0; k < 4; k++) x ^= hdr[8*k +: 8];
        for (int i = 0; i < nw; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) x ^= w[8*k +: 8];
        end
        return x;
    endfunction

    // Starts and ends at a negedge; optional random gaps, optionally with start noise.
    task automatic send_byte(input logic [7:0] b, input bit stall, input bit noise);
        int guard = 0;
        if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                start = noise && ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
        end
        start = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 64 cycles");
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] hdr, input bit stall);
        for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], stall, 1'b0);
    endtask

    task automatic send_word(input int i, input bit stall);
        wr_t         e;
        logic [31:0] w;
        e.addr = BASE + 32'(4 * i);
        e.data = words[i];
        exp_q.push_back(e);
        w = words[i];
        for (int k = 0; k < 4; k++) begin
            if (stall && i == 1 && k == 2) begin
                // Guaranteed start pulse in the middle of DATA.
                in_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(w[8*k +: 8], stall, stall);
        end
    endtask

    task automatic send_frame(input int nw, input logic [7:0] csum, input bit stall);
        send_hdr(32'(nw), stall);
        for (int i = 0; i < nw; i++) send_word(i, stall);
        send_byte(csum, stall, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        starts++;
        @(negedge clk);
        start = 1'b0;
        check_bit("clr_mem_reset", mem_reset, 1'b1);
        check_bit("clr_core_reset", core_reset, 1'b1);
        check_bit("clr_done", done, 1'b0);
        check_bit("clr_err", err, 1'b0);
        @(negedge clk);
        check_bit("hdr_mem_reset_low", mem_reset, 1'b0);
        check_bit("hdr_in_ready", in_ready, 1'b1);
    endtask

    task automatic check_reset_values();
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_rom_wen", rom_wen, 1'b0);
        check("rst_rom_wdata", rom_wdata, 32'h0);
        check("rst_rom_addr", rom_addr, BASE);
        check_bit("rst_mem_reset", mem_reset, 1'b0);
        check_bit("rst_core_reset", core_reset, 1'b1);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
    endtask

    task automatic check_end(input string tag, input logic exp_done);
        $display("frame %s done=%b err=%b core_reset=%b", tag, done, err, core_reset);
        check_bit({tag, "_done"}, done, exp_done);
        check_bit({tag, "_err"}, err, !exp_done);
        check_bit({tag, "_core_reset"}, core_reset, !exp_done);
        check_bit({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int pulses_before;

        // Reset.
        repeat (3) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        @(negedge clk);
        check_bit("idle_in_ready", in_ready, 1'b0);
        check_bit("idle_core_reset", core_reset, 1'b1);

        // N=2 good frame. Bytes 02 00 00 00 93 00 10 00 67 80 00 00 XOR to 0x66.
        words[0] = 32'h0010_0093;
        words[1] = 32'h0000_8067;
        pulse_start();
        send_frame(2, 8'h66, 1'b0);
        check_end("good2", 1'b1);

        // Same frame, wrong checksum: writes still happen, core stays held.
        pulse_start();
        send_frame(2, 8'hF7, 1'b0);
        check_end("badcsum", 1'b0);

        // Empty image.
        pulse_start();
        send_hdr(32'd0, 1'b0);
        check_bit("n0_in_ready_csum", in_ready, 1'b1);
        send_byte(8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_end("n0", 1'b1);

        // Oversized header 4097 = bytes 01 10 00 00.
        pulse_start();
        send_hdr(32'd4097, 1'b0);
        check_bit("big_err", err, 1'b1);
        check_bit("big_in_ready", in_ready, 1'b0);
        check_bit("big_done", done, 1'b0);
        check_bit("big_core_reset", core_reset, 1'b1);
        repeat (3) @(negedge clk);
        check_bit("big_err_hold", err, 1'b1);

        // N=4 unstalled, then the same frame with random gaps and start noise.
        words[0] = 32'h1234_5678;
        words[1] = 32'hDEAD_BEEF;
        words[2] = 32'h0000_0013;
        words[3] = 32'hFFFF_FFFF;
        pulse_start();
        send_frame(4, frame_csum(32'd4, 4), 1'b0);
        check_end("n4", 1'b1);
        pulses_before = mem_pulses;
        pulse_start();
        send_frame(4, frame_csum(32'd4, 4), 1'b1);
        check_end("n4stall", 1'b1);
        check("n4stall_mem_pulses", 32'(mem_pulses - pulses_before), 32'd1);

        // Reset in the middle of an N=3 load, then a full reload.
        words[0] = 32'hA5A5_0001;
        words[1] = 32'h5A5A_0002;
        words[2] = 32'h0F0F_0003;
        pulse_start();
        send_hdr(32'd3, 1'b0);
        send_word(0, 1'b0);
        send_word(1, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_frame(3, frame_csum(32'd3, 3), 1'b0);
        check_end("n3reload", 1'b1);

        @(negedge clk);
        check("mem_reset_pulses", 32'(mem_pulses), 32'(starts));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no end of test expected finish before 500000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
